// File: rtl/cpu_mem_seq_pkg.sv
// cpu_mem_seq_pkg: shared state encoding and CPU bus widths for the CPU-to-memory sequencer.
package cpu_mem_seq_pkg;
    localparam int CPU_ADDR_W = 16;
    localparam int CPU_DATA_W = 8;
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;
endpackage

// File: rtl/cpu_byte_lane.sv
// cpu_byte_lane: maps a CPU byte onto a 32-bit word (strobe, replicated write data, read-byte select).
module cpu_byte_lane
    import cpu_mem_seq_pkg::*;
(
    input  logic [1:0]            lane,
    input  logic                  we,
    input  logic [CPU_DATA_W-1:0] wbyte,
    input  logic [31:0]           rdata,
    output logic [3:0]            wstrb,
    output logic [31:0]           wdata,
    output logic [CPU_DATA_W-1:0] rbyte
);
    assign wstrb = we ? 4'b0001 << lane : 4'b0000;
    assign wdata = {4{wbyte}};
    assign rbyte = rdata[{lane, 3'b000} +: CPU_DATA_W];
endmodule

// File: rtl/cpu_mem_sequencer.sv
// cpu_mem_sequencer: stretches each 65C02 bus cycle onto a 32-bit valid/ready memory port.
// Define BUS_TIMEOUT_EN to abort stalled accesses after TIMEOUT_CYCLES and raise o_timeout.
module cpu_mem_sequencer
    import cpu_mem_seq_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE       = '0,
    parameter int                    TIMEOUT_CYCLES = 255
) (
    input  logic                    i_sysclk,
    input  logic                    i_rst,
    input  logic                    i_cpu_cycle_start,
    input  logic [CPU_ADDR_W-1:0]   i_cpu_addr,
    input  logic                    i_cpu_rwb,
    input  logic [CPU_DATA_W-1:0]   i_cpu_data,
    output logic [CPU_DATA_W-1:0]   o_cpu_data,
    output logic                    o_cpu_rdy,
    output logic                    o_mem_req_valid,
    input  logic                    i_mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic                    o_mem_we,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0] o_mem_wstrb,
    input  logic                    i_mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
    output logic                    o_busy,
    output logic                    o_timeout
);
    state_t                state;
    logic [1:0]            lane;
    logic [1:0]            sel;
    logic [3:0]            wstrb;
    logic [DATA_WIDTH-1:0] wdata;
    logic [CPU_DATA_W-1:0] rbyte;
    logic                  got_rsp;
    logic                  expired;
    logic                  finish;

    if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("cpu_mem_sequencer: DATA_WIDTH must be 32 and TIMEOUT_CYCLES positive");
    end

    // Live CPU lane builds the request at start; the latched lane picks the read byte.
    assign sel = (state == WAIT_RSP) ? lane : i_cpu_addr[1:0];

    cpu_byte_lane u_lane (
        .lane  (sel),
        .we    (~i_cpu_rwb),
        .wbyte (i_cpu_data),
        .rdata (i_mem_rdata),
        .wstrb (wstrb),
        .wdata (wdata),
        .rbyte (rbyte)
    );

    assign got_rsp = state == WAIT_RSP && i_mem_rsp_valid;
    assign finish  = got_rsp || expired;

`ifdef BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    assign expired = (state == REQ || state == WAIT_RSP) && cnt == CW'(TIMEOUT_CYCLES);
    always_ff @(posedge i_sysclk or posedge i_rst) begin
        if (i_rst) cnt <= '0;
        else cnt <= (state == REQ || state == WAIT_RSP) ? cnt + 1'b1 : '0;
    end
`else
    assign expired   = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_sysclk or posedge i_rst) begin
        if (i_rst) begin
            state           <= IDLE;
            lane            <= '0;
            o_cpu_rdy       <= 1'b1;
            o_cpu_data      <= '0;
            o_mem_req_valid <= 1'b0;
            o_mem_we        <= 1'b0;
            o_mem_addr      <= '0;
            o_mem_wdata     <= '0;
            o_mem_wstrb     <= '0;
            o_busy          <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            o_timeout       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: if (i_cpu_cycle_start) begin
                    state           <= REQ;
                    lane            <= i_cpu_addr[1:0];
                    o_mem_addr      <= MEM_BASE + ADDR_WIDTH'({i_cpu_addr[CPU_ADDR_W-1:2], 2'b00});
                    o_mem_we        <= ~i_cpu_rwb;
                    o_mem_wdata     <= wdata;
                    o_mem_wstrb     <= wstrb;
                    o_mem_req_valid <= 1'b1;
                    o_cpu_rdy       <= 1'b0;
                    o_busy          <= 1'b1;
                end
                REQ, WAIT_RSP: if (finish) begin
                    state           <= DONE;
                    o_mem_req_valid <= 1'b0;
                    o_cpu_rdy       <= 1'b1;
                    o_busy          <= 1'b0;
                    if (!o_mem_we) o_cpu_data <= got_rsp ? rbyte : 8'hFF;
`ifdef BUS_TIMEOUT_EN
                    if (!got_rsp) o_timeout <= 1'b1;
`endif
                end else if (state == REQ && i_mem_req_ready) begin
                    state           <= WAIT_RSP;
                    o_mem_req_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_mem_sequencer.sv
// tb_cpu_mem_sequencer: directed and randomized CPU accesses checked against a word-array memory model.
module tb_cpu_mem_sequencer;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          TO   = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic        cpu_rwb = 1'b1;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_rdy;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        rsp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy;
    logic        timeout;

    logic [31:0] mem [16384];
    logic [7:0]  exp_data = '0;
    logic        exp_to = 1'b0;
    int          accepts = 0;
    int          total = 0;
    int          passed = 0;
    int          fails = 0;

    cpu_mem_sequencer #(.MEM_BASE(BASE), .TIMEOUT_CYCLES(TO)) dut (
        .i_sysclk          (clk),
        .i_rst             (rst),
        .i_cpu_cycle_start (start),
        .i_cpu_addr        (cpu_addr),
        .i_cpu_rwb         (cpu_rwb),
        .i_cpu_data        (cpu_wdata),
        .o_cpu_data        (cpu_rdata),
        .o_cpu_rdy         (cpu_rdy),
        .o_mem_req_valid   (req_valid),
        .i_mem_req_ready   (req_ready),
        .o_mem_addr        (mem_addr),
        .o_mem_we          (mem_we),
        .o_mem_wdata       (mem_wdata),
        .o_mem_wstrb       (mem_wstrb),
        .i_mem_rsp_valid   (rsp_valid),
        .i_mem_rdata       (mem_rdata),
        .o_busy            (busy),
        .o_timeout         (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (req_valid && req_ready) accepts++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rdy"}, 32'(cpu_rdy), 32'd1);
        check({tag, "_cpu_data"}, 32'(cpu_rdata), 32'd0);
        check({tag, "_valid"}, 32'(req_valid), 32'd0);
        check({tag, "_we"}, 32'(mem_we), 32'd0);
        check({tag, "_addr"}, mem_addr, 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_wstrb"}, 32'(mem_wstrb), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    // Called at a negedge; a call right after another one starts the access straight from DONE.
    task automatic access(input logic [15:0] a, input logic rwb, input logic [7:0] d,
                          input int rwait, input int rlat);
        logic [31:0] e_addr;
        logic [3:0]  e_strb;
        logic [31:0] word;
        int          low;
        int          acc0;
        e_addr = BASE + {16'h0, a & 16'hFFFC};
        e_strb = rwb ? 4'h0 : 4'h1 << a[1:0];
        acc0 = accepts;
        low = 0;
        cpu_addr = a; cpu_rwb = rwb; cpu_wdata = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cpu_addr = 16'($urandom); cpu_rwb = 1'($urandom); cpu_wdata = 8'($urandom);
        check("req_valid", 32'(req_valid), 32'd1);
        check("req_addr", mem_addr, e_addr);
        check("req_we", 32'(mem_we), 32'(!rwb));
        check("req_wstrb", 32'(mem_wstrb), 32'(e_strb));
        if (!rwb) check("req_wdata", mem_wdata, {4{d}});
        check("req_busy", 32'(busy), 32'd1);
        for (int i = 0; i < rwait; i++) begin
            if (!cpu_rdy) low++;
            rsp_valid = (i == 0);
            mem_rdata = $urandom;
            @(negedge clk);
            check("hold_valid", 32'(req_valid), 32'd1);
            check("hold_addr", mem_addr, e_addr);
            check("hold_wstrb", 32'(mem_wstrb), 32'(e_strb));
        end
        if (!cpu_rdy) low++;
        req_ready = 1'b1;
        rsp_valid = 1'($urandom);
        mem_rdata = $urandom;
        @(negedge clk);
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        check("accept_valid_low", 32'(req_valid), 32'd0);
        for (int i = 0; i < rlat; i++) begin
            if (!cpu_rdy) low++;
            @(negedge clk);
        end
        if (!cpu_rdy) low++;
        word = mem[a[15:2]];
        rsp_valid = 1'b1;
        mem_rdata = rwb ? word : $urandom;
        @(negedge clk);
        rsp_valid = 1'b0;
        mem_rdata = $urandom;
        if (rwb) exp_data = word[8*a[1:0] +: 8];
        else mem[a[15:2]][8*a[1:0] +: 8] = d;
        check("done_rdy", 32'(cpu_rdy), 32'd1);
        check("done_cpu_data", 32'(cpu_rdata), 32'(exp_data));
        check("rdy_low_cycles", low, 2 + rwait + rlat);
        check("accept_count", accepts - acc0, 1);
        check("done_busy", 32'(busy), 32'd0);
        check("timeout_flag", 32'(timeout), 32'(exp_to));
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        mem[16'h1235 >> 2] = 32'hAABBCCDD;
        access(16'h1235, 1'b1, 8'h00, 0, 3);
        check("read_1235_byte", 32'(cpu_rdata), 32'hCC);
        access(16'h0003, 1'b0, 8'h42, 0, 0);
        access(16'h2002, 1'b0, 8'h5A, 5, 1);
        access(16'h2002, 1'b1, 8'h00, 2, 0);
        check("readback_5a", 32'(cpu_rdata), 32'h5A);

`ifdef BUS_TIMEOUT_EN
        begin
            int n;
            cpu_addr = 16'h0010; cpu_rwb = 1'b1; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n = 0;
            while (!cpu_rdy && n < 100) begin
                req_ready = (n == 0);
                n++;
                @(negedge clk);
            end
            req_ready = 1'b0;
            exp_data = 8'hFF;
            exp_to = 1'b1;
            check("timeout_latency", n, TO + 1);
            check("timeout_cpu_data", 32'(cpu_rdata), 32'hFF);
            check("timeout_set", 32'(timeout), 32'd1);
            check("timeout_valid", 32'(req_valid), 32'd0);
            access(16'h0011, 1'b1, 8'h00, 1, 1);
        end
`endif

        cpu_addr = 16'h0008; cpu_rwb = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        check("wait_rdy_low", 32'(cpu_rdy), 32'd0);
        rst = 1'b1;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        rst = 1'b0;
        exp_data = 8'h00;
        exp_to = 1'b0;
        @(negedge clk);
        rsp_valid = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        rsp_valid = 1'b0;
        check_reset_values("stale_rsp");

        for (int k = 0; k < 40; k++) begin
            logic [15:0] a;
            a = ($urandom % 2 == 0) ? 16'($urandom_range(0, 31)) : 16'($urandom_range(16'hFFE0, 16'hFFFF));
            access(a, (k % 3 == 1) ? 1'($urandom) : (k % 2 == 0), 8'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
